// File: rtl/sudoku_mask_iter.sv
// sudoku_mask_iter
//   Clocked constraint-propagation engine for SIDE x SIDE sudoku candidate
//   masks (SIDE = BOX*BOX). A loaded mask is refined one rule pass per cycle
//   (line, box and peer rules, bits only ever set) until it is stable, solved,
//   contradictory, or the iteration limit is reached.
//
//   Mask layout: bit (x*SIDE + y)*SIDE + v = 1 means value v is excluded at
//   cell (x,y).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   load mask_in and begin (sampled only in IDLE)
//   mask_in    in   MW-bit candidate mask
//   busy       out  engine is iterating
//   out_valid  out  result held valid (DONE)
//   out_ready  in   consumer accepts the result
//   mask_out   out  final registered mask
//   status     out  0=STABLE 1=SOLVED 2=CONTRADICTION 3=TIMEOUT
//   iter_cnt   out  number of rule passes executed
//   elim_cnt   out  total bits newly set over all passes (optional)
//
// Optional feature: define SUDOKU_MASK_ITER_STATS_EN to add elim_cnt.
module sudoku_mask_iter #(
    parameter int BOX      = 3,
    parameter int MAX_ITER = 32,
    parameter int CW       = 6,
    localparam int SIDE    = BOX * BOX,
    localparam int MW      = SIDE * SIDE * SIDE
`ifdef SUDOKU_MASK_ITER_STATS_EN
    ,
    localparam int EW      = $clog2(MW + 1)
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [MW-1:0] mask_in,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] mask_out,
    output logic [1:0]    status,
    output logic [CW-1:0] iter_cnt
`ifdef SUDOKU_MASK_ITER_STATS_EN
    ,
    output logic [EW-1:0] elim_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [MW-1:0]   r_mask;
    logic [1:0]      r_status;
    logic [CW-1:0]   r_iter_cnt;

    logic [SIDE-1:0] w_cur    [SIDE][SIDE];
    logic [SIDE-1:0] w_elim_c [SIDE][SIDE];
    logic [MW-1:0]   w_elim;
    logic [MW-1:0]   w_next;

    // Per-unit, per-value counts: how many cells leave the value open, and
    // how many of those are already resolved to that value.
    int              w_row_open [SIDE][SIDE];
    int              w_col_open [SIDE][SIDE];
    int              w_box_open [SIDE][SIDE];
    int              w_row_fix  [SIDE][SIDE];
    int              w_col_fix  [SIDE][SIDE];
    int              w_box_fix  [SIDE][SIDE];
    logic            w_single   [SIDE][SIDE];

    logic            w_contra;
    logic            w_solved;
    logic            w_stable;
    logic            w_timeout;
    logic            w_exit;
    logic [1:0]      w_status_nxt;
    logic [CW-1:0]   w_iter_inc;

    genvar gx, gy;
    generate
        for (gx = 0; gx < SIDE; gx++) begin : g_row
            for (gy = 0; gy < SIDE; gy++) begin : g_col
                assign w_cur[gx][gy] = r_mask[(gx*SIDE + gy)*SIDE +: SIDE];
                assign w_elim[(gx*SIDE + gy)*SIDE +: SIDE] = w_elim_c[gx][gy];
            end
        end
    endgenerate

    assign w_next = r_mask | w_elim;

    // ---- rule pass: combinational elimination from the current mask ----
    always_comb begin
        int              bi;
        int              self_fix;
        logic            open_v;
        logic [SIDE-1:0] hid;
        bi       = 0;
        self_fix = 0;
        open_v   = 1'b0;
        hid      = '0;
        for (int a = 0; a < SIDE; a++) begin
            for (int v = 0; v < SIDE; v++) begin
                w_row_open[a][v] = 0;
                w_col_open[a][v] = 0;
                w_box_open[a][v] = 0;
                w_row_fix[a][v]  = 0;
                w_col_fix[a][v]  = 0;
                w_box_fix[a][v]  = 0;
            end
        end
        for (int x = 0; x < SIDE; x++) begin
            for (int y = 0; y < SIDE; y++) begin
                w_single[x][y] = ($countones(~w_cur[x][y]) == 1);
                w_elim_c[x][y] = '0;
            end
        end
        for (int x = 0; x < SIDE; x++) begin
            for (int y = 0; y < SIDE; y++) begin
                bi = (x / BOX) * BOX + (y / BOX);
                for (int v = 0; v < SIDE; v++) begin
                    if (!w_cur[x][y][v]) begin
                        w_row_open[x][v]  += 1;
                        w_col_open[y][v]  += 1;
                        w_box_open[bi][v] += 1;
                        if (w_single[x][y]) begin
                            w_row_fix[x][v]  += 1;
                            w_col_fix[y][v]  += 1;
                            w_box_fix[bi][v] += 1;
                        end
                    end
                end
            end
        end
        for (int x = 0; x < SIDE; x++) begin
            for (int y = 0; y < SIDE; y++) begin
                bi  = (x / BOX) * BOX + (y / BOX);
                hid = '0;
                for (int v = 0; v < SIDE; v++) begin
                    open_v   = !w_cur[x][y][v];
                    // A resolved cell must not eliminate its own value.
                    self_fix = (open_v && w_single[x][y]) ? 1 : 0;
                    w_elim_c[x][y][v] = (w_row_fix[x][v]  > self_fix) ||
                                        (w_col_fix[y][v]  > self_fix) ||
                                        (w_box_fix[bi][v] > self_fix);
                    if (open_v && (w_row_open[x][v] == 1 || w_col_open[y][v] == 1 ||
                                   w_box_open[bi][v] == 1))
                        hid[v] = 1'b1;
                end
                // A hidden single v excludes every other value at this cell.
                for (int u = 0; u < SIDE; u++) begin
                    if ((hid & ~(SIDE'(1) << u)) != '0)
                        w_elim_c[x][y][u] = 1'b1;
                end
            end
        end
    end

    // ---- exit checks on the next mask ----
    always_comb begin
        logic [SIDE-1:0] nc;
        nc       = '0;
        w_contra = 1'b0;
        w_solved = 1'b1;
        for (int x = 0; x < SIDE; x++) begin
            for (int y = 0; y < SIDE; y++) begin
                nc = w_cur[x][y] | w_elim_c[x][y];
                if (&nc)
                    w_contra = 1'b1;
                if ($countones(~nc) != 1)
                    w_solved = 1'b0;
            end
        end
    end

    assign w_stable   = (w_next == r_mask);
    assign w_iter_inc = r_iter_cnt + 1'b1;
    assign w_timeout  = (w_iter_inc == CW'(MAX_ITER));
    assign w_exit     = w_contra | w_solved | w_stable | w_timeout;

    always_comb begin
        if (w_contra)
            w_status_nxt = 2'd2;
        else if (w_solved)
            w_status_nxt = 2'd1;
        else if (w_stable)
            w_status_nxt = 2'd0;
        else
            w_status_nxt = 2'd3;
    end

    // ---- control FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_state_nxt = S_ITER;
            S_ITER:  if (w_exit)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_ITER);
        out_valid = (r_state == S_DONE);
    end

    // ---- mask / status / counter registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_status   <= 2'd0;
            r_iter_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask     <= mask_in;
                        r_iter_cnt <= '0;
                    end
                end
                S_ITER: begin
                    // On exit the register holds next, which is the result.
                    r_mask     <= w_next;
                    r_iter_cnt <= w_iter_inc;
                    if (w_exit)
                        r_status <= w_status_nxt;
                end
                default: ;
            endcase
        end
    end

    assign mask_out = r_mask;
    assign status   = r_status;
    assign iter_cnt = r_iter_cnt;

`ifdef SUDOKU_MASK_ITER_STATS_EN
    logic [EW-1:0] r_elim_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_elim_cnt <= '0;
        else if (r_state == S_IDLE && start)
            r_elim_cnt <= '0;
        else if (r_state == S_ITER)
            r_elim_cnt <= r_elim_cnt + EW'($countones(w_next & ~r_mask));
    end

    assign elim_cnt = r_elim_cnt;
`endif

endmodule

// File: tb/tb_sudoku_mask_iter.sv
// Testbench for sudoku_mask_iter: a BOX=2 instance (MAX_ITER=3) for directed
// and randomized runs, and a BOX=3 instance (MAX_ITER=1) for the 9x9 cases.
module tb_sudoku_mask_iter;

    localparam int MIA = 3;
    localparam int MIB = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;

    logic         a_start, a_ready, a_busy, a_vld;
    logic [63:0]  a_min, a_mout;
    logic [1:0]   a_st;
    logic [1:0]   a_it;

    logic         b_start, b_ready, b_busy, b_vld;
    logic [728:0] b_min, b_mout;
    logic [1:0]   b_st;
    logic [0:0]   b_it;

`ifdef SUDOKU_MASK_ITER_STATS_EN
    logic [6:0]   a_ec;
    logic [9:0]   b_ec;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sudoku_mask_iter #(.BOX(2), .MAX_ITER(MIA), .CW(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mask_in(a_min),
        .busy(a_busy), .out_valid(a_vld), .out_ready(a_ready),
        .mask_out(a_mout), .status(a_st), .iter_cnt(a_it)
`ifdef SUDOKU_MASK_ITER_STATS_EN
        , .elim_cnt(a_ec)
`endif
    );

    sudoku_mask_iter #(.BOX(3), .MAX_ITER(MIB), .CW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mask_in(b_min),
        .busy(b_busy), .out_valid(b_vld), .out_ready(b_ready),
        .mask_out(b_mout), .status(b_st), .iter_cnt(b_it)
`ifdef SUDOKU_MASK_ITER_STATS_EN
        , .elim_cnt(b_ec)
`endif
    );

    task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (candidate-set view) ----------------
    function automatic bit m_open(input logic [728:0] m, input int s, input int x, input int y, input int v);
        return !m[(x*s + y)*s + v];
    endfunction

    function automatic int m_cands(input logic [728:0] m, input int s, input int x, input int y);
        int n = 0;
        for (int v = 0; v < s; v++) if (m_open(m, s, x, y, v)) n++;
        return n;
    endfunction

    // kind 0 = row, 1 = column, 2 = box
    function automatic bit m_unit(input int box, input int kind, input int x, input int y, input int p, input int q);
        if (kind == 0) return x == p;
        if (kind == 1) return y == q;
        return (x / box == p / box) && (y / box == q / box);
    endfunction

    function automatic logic [728:0] m_pass(input logic [728:0] m, input int box);
        logic [728:0] nx;
        int s;
        int n;
        bit hit;
        s  = box * box;
        nx = m;
        for (int x = 0; x < s; x++)
            for (int y = 0; y < s; y++)
                for (int u = 0; u < s; u++) begin
                    if (!m_open(m, s, x, y, u)) continue;
                    hit = 0;
                    // some other peer cell is already fixed to u
                    for (int p = 0; p < s; p++)
                        for (int q = 0; q < s; q++)
                            if (!(p == x && q == y) &&
                                (m_unit(box, 0, x, y, p, q) || m_unit(box, 1, x, y, p, q) ||
                                 m_unit(box, 2, x, y, p, q)) &&
                                m_cands(m, s, p, q) == 1 && m_open(m, s, p, q, u))
                                hit = 1;
                    // this cell is the sole home of some other value v in a unit
                    for (int v = 0; v < s; v++) begin
                        if (v == u || !m_open(m, s, x, y, v)) continue;
                        for (int k = 0; k < 3; k++) begin
                            n = 0;
                            for (int p = 0; p < s; p++)
                                for (int q = 0; q < s; q++)
                                    if (m_unit(box, k, x, y, p, q) && m_open(m, s, p, q, v)) n++;
                            if (n == 1) hit = 1;
                        end
                    end
                    if (hit) nx[(x*s + y)*s + u] = 1'b1;
                end
        return nx;
    endfunction

    task automatic m_run(input logic [728:0] m, input int box, input int maxit,
                         output logic [728:0] mo, output int st, output int it, output int el);
        logic [728:0] cur, nx;
        int  s;
        bit  contra, solved;
        s = box * box; cur = m; it = 0; el = 0; st = 0; mo = m;
        while (1) begin
            nx = m_pass(cur, box);
            it++;
            el += $countones(nx & ~cur);
            contra = 0; solved = 1;
            for (int x = 0; x < s; x++)
                for (int y = 0; y < s; y++) begin
                    if (m_cands(nx, s, x, y) == 0) contra = 1;
                    if (m_cands(nx, s, x, y) != 1) solved = 0;
                end
            mo = nx;
            if (contra)           begin st = 2; break; end
            else if (solved)      begin st = 1; break; end
            else if (nx == cur)   begin st = 0; break; end
            else if (it == maxit) begin st = 3; break; end
            cur = nx;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic make_sol(input int box, input bit shuf, output logic [728:0] solm);
        int s, v, j, t;
        int perm [9];
        s = box * box;
        for (int i = 0; i < 9; i++) perm[i] = i;
        if (shuf)
            for (int i = s - 1; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
        solm = '0;
        for (int x = 0; x < s; x++)
            for (int y = 0; y < s; y++) begin
                v = perm[(x*box + x/box + y) % s];
                for (int u = 0; u < s; u++)
                    if (u != v) solm[(x*s + y)*s + u] = 1'b1;
            end
    endtask

    function automatic logic [728:0] open_cell(input logic [728:0] m, input int s, input int x, input int y);
        for (int v = 0; v < s; v++) m[(x*s + y)*s + v] = 1'b0;
        return m;
    endfunction

    task automatic rand_puzzle(input int open_pct, output logic [728:0] m);
        logic [728:0] solm;
        make_sol(2, 1'b1, solm);
        m = solm;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                if (int'($urandom_range(99, 0)) < open_pct) begin
                    m = open_cell(m, 4, x, y);
                    for (int u = 0; u < 4; u++)
                        if (solm[(x*4 + y)*4 + u] && $urandom_range(2, 0) == 0)
                            m[(x*4 + y)*4 + u] = 1'b1;
                end
    endtask

    task automatic run_a(input logic [728:0] m, output int lat);
        @(negedge clk); a_min = m[63:0]; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("a_busy_after_start", 729'(a_busy), 729'(1));
        lat = 1;
        while (!a_vld && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic run_b(input logic [728:0] m, output int lat);
        @(negedge clk); b_min = m; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        lat = 1;
        while (!b_vld && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic check_a(input string tg, input logic [728:0] mo, input int st, input int it,
                           input int el, input int lat);
        chk({tg, "_status"},  729'(a_st),   729'(st));
        chk({tg, "_iter"},    729'(a_it),   729'(it));
        chk({tg, "_mask"},    729'(a_mout), mo);
        chk({tg, "_latency"}, 729'(lat),    729'(it + 1));
        chk({tg, "_busy"},    729'(a_busy), 729'(0));
`ifdef SUDOKU_MASK_ITER_STATS_EN
        chk({tg, "_elim"},    729'(a_ec),   729'(el));
`else
        if (el < 0) chk({tg, "_elim_neg"}, 729'(el), 729'(0));
`endif
    endtask

    task automatic ack_a(input string tg);
        @(negedge clk); a_ready = 1'b1;
        @(negedge clk); a_ready = 1'b0;
        chk({tg, "_ack_valid"}, 729'(a_vld),  729'(0));
        chk({tg, "_ack_busy"},  729'(a_busy), 729'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [728:0] m, solm, mo, mo2;
        int st, it, el, lat;
        int st2, it2, el2;

        a_start = 1'b0; a_ready = 1'b0; a_min = '0;
        b_start = 1'b0; b_ready = 1'b0; b_min = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_busy",   729'(a_busy), 729'(0));
        chk("rst_a_valid",  729'(a_vld),  729'(0));
        chk("rst_a_status", 729'(a_st),   729'(0));
        chk("rst_a_iter",   729'(a_it),   729'(0));
        chk("rst_a_mask",   729'(a_mout), 729'(0));
        chk("rst_b_mask",   b_mout,       729'(0));
        chk("rst_b_valid",  729'(b_vld),  729'(0));
        rst_n = 1'b1;

        // 4x4 with one open cell: solved in one pass
        make_sol(2, 1'b0, solm);
        m = open_cell(solm, 4, 2, 1);
        run_a(m, lat);
        check_a("t1", solm, 1, 1, 3, lat);
        ack_a("t1");

        // DONE holds against start while out_ready is low
        rand_puzzle(60, m);
        m_run(m, 2, MIA, mo, st, it, el);
        run_a(m, lat);
        check_a("t5", mo, st, it, el, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_start = (i == 3);
            a_min   = {$urandom, $urandom};
        end
        @(negedge clk); a_start = 1'b0;
        chk("t5_hold_valid",  729'(a_vld),  729'(1));
        chk("t5_hold_mask",   729'(a_mout), mo);
        chk("t5_hold_status", 729'(a_st),   729'(st));
        chk("t5_hold_iter",   729'(a_it),   729'(it));
        // start together with out_ready in DONE: handshake only
        a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk); a_start = 1'b0; a_ready = 1'b0;
        chk("t5_ack_valid", 729'(a_vld),  729'(0));
        chk("t5_ack_busy",  729'(a_busy), 729'(0));
        @(negedge clk);
        chk("t5_no_reload", 729'(a_busy), 729'(0));
        chk("t5_keep_mask", 729'(a_mout), mo);

        // randomized runs against the model
        for (int r = 0; r < 24; r++) begin
            if (r % 3 == 2) begin
                m = '0;
                m[63:0] = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            end else begin
                rand_puzzle((r % 3 == 0) ? 40 : 85, m);
            end
            m_run(m, 2, MIA, mo, st, it, el);
            run_a(m, lat);
            check_a($sformatf("rnd%0d", r), mo, st, it, el, lat);
            ack_a($sformatf("rnd%0d", r));
        end

        // asynchronous reset in the middle of iteration
        make_sol(2, 1'b0, solm);
        m = solm;
        for (int k = 0; k < 4; k++) begin
            m = open_cell(m, 4, 0, k);
            m = open_cell(m, 4, k, 0);
        end
        @(negedge clk); a_min = m[63:0]; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        @(negedge clk);
        chk("t6_busy_pass2", 729'(a_busy), 729'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",   729'(a_busy), 729'(0));
        chk("t6_rst_valid",  729'(a_vld),  729'(0));
        chk("t6_rst_status", 729'(a_st),   729'(0));
        chk("t6_rst_iter",   729'(a_it),   729'(0));
        chk("t6_rst_mask",   729'(a_mout), 729'(0));
`ifdef SUDOKU_MASK_ITER_STATS_EN
        chk("t6_rst_elim",   729'(a_ec),   729'(0));
`endif
        @(negedge clk); rst_n = 1'b1;
        m_run(m, 2, MIA, mo, st, it, el);
        run_a(m, lat);
        check_a("t6_after", mo, st, it, el, lat);
        ack_a("t6_after");

        // 9x9: all-open grid is stable after one pass
        run_b('0, lat);
        chk("t2_status",  729'(b_st),  729'(0));
        chk("t2_iter",    729'(b_it),  729'(1));
        chk("t2_mask",    b_mout,      729'(0));
        chk("t2_latency", 729'(lat),   729'(2));
`ifdef SUDOKU_MASK_ITER_STATS_EN
        chk("t2_elim",    729'(b_ec),  729'(0));
`endif
        @(negedge clk); b_ready = 1'b1; @(negedge clk); b_ready = 1'b0;
        chk("t2_ack_valid", 729'(b_vld), 729'(0));

        // 9x9: cell (0,0) fully excluded on input
        m = '0;
        for (int v = 0; v < 9; v++) m[v] = 1'b1;
        m_run(m, 3, MIB, mo, st2, it2, el2);
        run_b(m, lat);
        chk("t3_status",  729'(b_st), 729'(2));
        chk("t3_iter",    729'(b_it), 729'(1));
        chk("t3_mask",    b_mout,     mo);
        chk("t3_latency", 729'(lat),  729'(2));
        @(negedge clk); b_ready = 1'b1; @(negedge clk); b_ready = 1'b0;

        // 9x9 with row 0 and column 0 open: needs 2+ passes, limit is 1
        make_sol(3, 1'b0, solm);
        m = solm;
        for (int k = 0; k < 9; k++) begin
            m = open_cell(m, 9, 0, k);
            m = open_cell(m, 9, k, 0);
        end
        mo2 = m_pass(m, 3);
        m_run(m, 3, MIB, mo, st2, it2, el2);
        run_b(m, lat);
        chk("t4_status",  729'(b_st), 729'(3));
        chk("t4_iter",    729'(b_it), 729'(1));
        chk("t4_mask",    b_mout,     mo2);
        chk("t4_latency", 729'(lat),  729'(2));
`ifdef SUDOKU_MASK_ITER_STATS_EN
        chk("t4_elim",    729'(b_ec), 729'(el2));
`endif
        @(negedge clk); b_ready = 1'b1; @(negedge clk); b_ready = 1'b0;
        chk("t4_ack_valid", 729'(b_vld), 729'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
